// File: rtl/cdd_link_if.sv
// cdd_link_if -- CDD 4-bit handshake bus between the CD host and the drive.
//
// Signals:
//   HOCK      host handshake (host -> drive)
//   CDCK      drive handshake (drive -> host), idles high
//   CDD_DIN   host-to-drive nibble
//   CDD_DOUT  drive-to-host nibble
//   CDD_nIRQ  drive communication request, active low
//
// Handshake: a four-phase exchange. The drive requests a frame by pulling
// CDD_nIRQ low; the host acknowledges by pulling HOCK low. Per nibble the
// side presenting data signals "valid" (drive: CDCK low with DOUT stable,
// host: DIN stable then HOCK high) and the other side answers "ready" with the
// opposite handshake edge. Data must stay stable until the answering edge is
// seen, and neither side moves its handshake line again until the other has
// responded.
//
// Modports: slave = drive side (cdd_link), master = host side.
interface cdd_link_if;
  logic       HOCK;
  logic       CDCK;
  logic [3:0] CDD_DIN;
  logic [3:0] CDD_DOUT;
  logic       CDD_nIRQ;

  modport slave  (input HOCK, input CDD_DIN, output CDCK, output CDD_DOUT, output CDD_nIRQ);
  modport master (output HOCK, output CDD_DIN, input CDCK, input CDD_DOUT, input CDD_nIRQ);
endinterface

// File: rtl/cdd_link.sv
// cdd_link -- link-layer engine for the CDD 4-bit handshake bus.
//
// Every IRQ period the drive snapshots its status shadow, raises CDD_nIRQ,
// sends a NIBBLES-long status frame (last nibble = checksum) and then
// receives a NIBBLES-long command frame, delivered as one parallel word.
// All link logic advances on a tick strobe every DIV clk_sys cycles.
//
// Ports:
//   clk_sys, RESET   clock, asynchronous active-high reset
//   cdd              bus interface (slave modport)
//   play_mode        0: IRQ every IRQ_PERIOD_STOP ticks, 1: IRQ_PERIOD_PLAY
//   stat_wr/idx/data status shadow write port (idx >= NIBBLES-1 ignored)
//   cmd_valid        one-cycle pulse with a received command frame
//   cmd_data         received frame, nibble k at [4k+3:4k]
//   cmd_chk_err      frame delivered with a bad checksum
//   err_count        saturating count of bad-checksum frames
//   dbg_state        current link FSM state
//
// Optional feature: define CDD_LINK_CHKERR_EN to deliver bad-checksum frames
// flagged with cmd_chk_err and counted in err_count; otherwise bad frames are
// dropped and both outputs are tied to 0.
module cdd_link #(
  parameter int DIV             = 480,
  parameter int NIBBLES         = 10,
  parameter int CHK_SEED        = 5,
  parameter int IRQ_PERIOD_STOP = 3906,
  parameter int IRQ_PERIOD_PLAY = 3333,
  parameter int IRQ_HOLD        = 1953
) (
  input  logic                       clk_sys,
  input  logic                       RESET,
  cdd_link_if.slave                  cdd,
  input  logic                       play_mode,
  input  logic                       stat_wr,
  input  logic [$clog2(NIBBLES)-1:0] stat_idx,
  input  logic [3:0]                 stat_data,
  output logic                       cmd_valid,
  output logic [4*NIBBLES-1:0]       cmd_data,
  output logic                       cmd_chk_err,
  output logic [7:0]                 err_count,
  output logic [2:0]                 dbg_state
);

  localparam int          IW      = $clog2(NIBBLES);
  localparam int          SW      = 4 * (NIBBLES - 1);
  localparam logic [15:0] DIV_M1  = 16'(DIV - 1);
  localparam logic [15:0] STOP_M1 = 16'(IRQ_PERIOD_STOP - 1);
  localparam logic [15:0] PLAY_M1 = 16'(IRQ_PERIOD_PLAY - 1);
  localparam logic [15:0] HOLD_M1 = 16'(IRQ_HOLD - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S_PUT = 3'd1,
    S_WH  = 3'd2,
    S_WL  = 3'd3,
    R_WH  = 3'd4,
    R_WL  = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         div_q, div_d, cnt_q, cnt_d;
  logic                hock_prev_q, hock_prev_d, hock_old_q, hock_old_d;
  logic                cdck_q, cdck_d, nirq_q, nirq_d;
  logic [3:0]          dout_q, dout_d, i_q, i_d, j_q, j_d, rx_sum_q, rx_sum_d;
  logic [SW-1:0]       shadow_q, shadow_d, frame_q, frame_d;
  logic [4*NIBBLES-1:0] cmd_buf_q, cmd_buf_d, cmd_data_q, cmd_data_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic                tick, hock_rise, hock_fall;
  logic [15:0]         period_m1;
  logic [3:0]          chk_acc, chk_out, frame_nib;

`ifdef CDD_LINK_CHKERR_EN
  logic                chk_err_q, chk_err_d;
  logic [7:0]          err_q, err_d;
`endif

  assign tick      = (div_q == DIV_M1);
  // Edges are judged between two tick samples, so a HOCK edge is seen one
  // tick after it is first registered.
  assign hock_rise = hock_prev_q & ~hock_old_q;
  assign hock_fall = ~hock_prev_q & hock_old_q;
  assign period_m1 = play_mode ? PLAY_M1 : STOP_M1;

  // Checksum over the snapshot and the nibble addressed by the TX index.
  always_comb begin
    chk_acc   = 4'(CHK_SEED);
    frame_nib = '0;
    for (int k = 0; k < NIBBLES - 1; k++) begin
      chk_acc = chk_acc + frame_q[4*k +: 4];
      if (i_q == 4'(k)) frame_nib = frame_q[4*k +: 4];
    end
    chk_out = ~chk_acc;
  end

  always_comb begin
    state_d     = state_q;
    div_d       = tick ? 16'd0 : div_q + 16'd1;
    cnt_d       = cnt_q;
    hock_prev_d = hock_prev_q;
    hock_old_d  = hock_old_q;
    cdck_d      = cdck_q;
    nirq_d      = nirq_q;
    dout_d      = dout_q;
    i_d         = i_q;
    j_d         = j_q;
    rx_sum_d    = rx_sum_q;
    shadow_d    = shadow_q;
    frame_d     = frame_q;
    cmd_buf_d   = cmd_buf_q;
    cmd_data_d  = cmd_data_q;
    cmd_valid_d = 1'b0;
`ifdef CDD_LINK_CHKERR_EN
    chk_err_d   = 1'b0;
    err_d       = err_q;
`endif

    // Shadow write first so a same-cycle snapshot picks it up.
    for (int k = 0; k < NIBBLES - 1; k++) begin
      if (stat_wr && (stat_idx == IW'(k))) shadow_d[4*k +: 4] = stat_data;
    end

    if (tick) begin
      hock_prev_d = cdd.HOCK;
      hock_old_d  = hock_prev_q;
      if (cnt_q >= period_m1) begin
        // New request: aborts whatever frame was in flight.
        cnt_d   = 16'd0;
        nirq_d  = 1'b0;
        frame_d = shadow_d;
        i_d     = 4'd0;
        cdck_d  = 1'b1;
        state_d = S_PUT;
      end else begin
        cnt_d = cnt_q + 16'd1;
        if (!nirq_q) begin
          if (!hock_prev_q) begin
            nirq_d = 1'b1;
          end else if (cnt_q == HOLD_M1) begin
            // Host never answered: give up on this frame entirely.
            nirq_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          case (state_q)
            S_PUT: begin
              dout_d  = (i_q == 4'(NIBBLES - 1)) ? chk_out : frame_nib;
              cdck_d  = 1'b0;
              state_d = S_WH;
            end
            S_WH: if (hock_rise) begin
              cdck_d = 1'b1;
              if (i_q == 4'(NIBBLES - 1)) begin
                rx_sum_d = 4'(CHK_SEED);
                j_d      = 4'd0;
                state_d  = R_WL;
              end else begin
                state_d = S_WL;
              end
            end
            S_WL: if (hock_fall) begin
              i_d     = i_q + 4'd1;
              state_d = S_PUT;
            end
            R_WH: if (hock_rise) begin
              for (int k = 0; k < NIBBLES; k++) begin
                if (j_q == 4'(k)) cmd_buf_d[4*k +: 4] = cdd.CDD_DIN;
              end
              rx_sum_d = rx_sum_q + cdd.CDD_DIN;
              cdck_d   = 1'b1;
              j_d      = j_q + 4'd1;
              state_d  = R_WL;
            end
            R_WL: if (hock_fall) begin
              cdck_d  = 1'b0;
              state_d = (j_q == 4'(NIBBLES)) ? DONE : R_WH;
            end
            DONE: begin
              if (rx_sum_q == 4'hF) begin
                cmd_valid_d = 1'b1;
                cmd_data_d  = cmd_buf_q;
              end
`ifdef CDD_LINK_CHKERR_EN
              else begin
                cmd_valid_d = 1'b1;
                chk_err_d   = 1'b1;
                cmd_data_d  = cmd_buf_q;
                if (err_q != 8'hFF) err_d = err_q + 8'd1;
              end
`endif
              // Return the handshake line to its idle level.
              cdck_d  = 1'b1;
              state_d = IDLE;
            end
            default: state_d = IDLE;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      div_q       <= '0;
      cnt_q       <= '0;
      hock_prev_q <= 1'b1;
      hock_old_q  <= 1'b1;
      cdck_q      <= 1'b1;
      nirq_q      <= 1'b1;
      dout_q      <= '0;
      i_q         <= '0;
      j_q         <= '0;
      rx_sum_q    <= '0;
      shadow_q    <= '0;
      frame_q     <= '0;
      cmd_buf_q   <= '0;
      cmd_data_q  <= '0;
      cmd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      hock_prev_q <= hock_prev_d;
      hock_old_q  <= hock_old_d;
      cdck_q      <= cdck_d;
      nirq_q      <= nirq_d;
      dout_q      <= dout_d;
      i_q         <= i_d;
      j_q         <= j_d;
      rx_sum_q    <= rx_sum_d;
      shadow_q    <= shadow_d;
      frame_q     <= frame_d;
      cmd_buf_q   <= cmd_buf_d;
      cmd_data_q  <= cmd_data_d;
      cmd_valid_q <= cmd_valid_d;
    end
  end

`ifdef CDD_LINK_CHKERR_EN
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      chk_err_q <= 1'b0;
      err_q     <= '0;
    end else begin
      chk_err_q <= chk_err_d;
      err_q     <= err_d;
    end
  end
  assign cmd_chk_err = chk_err_q;
  assign err_count   = err_q;
`else
  assign cmd_chk_err = 1'b0;
  assign err_count   = 8'd0;
`endif

  assign cdd.CDCK     = cdck_q;
  assign cdd.CDD_DOUT = dout_q;
  assign cdd.CDD_nIRQ = nirq_q;
  assign cmd_valid    = cmd_valid_q;
  assign cmd_data     = cmd_data_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_cdd_link.sv
// tb_cdd_link -- directed bench for cdd_link with shortened timing
// (DIV=4, STOP=300, PLAY=250, HOLD=150 ticks; NIBBLES=10, seed 5).
// Status checksum = ~(5 + sum of status nibbles) mod 16.
module tb_cdd_link;
  localparam int DIV      = 4;
  localparam int N        = 10;
  localparam int PSTOP    = 300;
  localparam int PPLAY    = 250;
  localparam int HOLD     = 150;
  localparam int WAIT_LIM = 4000;

  logic        clk;
  logic        RESET;
  logic        play_mode;
  logic        stat_wr;
  logic [3:0]  stat_idx;
  logic [3:0]  stat_data;
  logic        cmd_valid;
  logic [39:0] cmd_data;
  logic        cmd_chk_err;
  logic [7:0]  err_count;
  logic [2:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  int          vcount = 0;
  logic [39:0] last_data = '0;
  logic        last_err  = 1'b0;

  cdd_link_if cdd();

  cdd_link #(
    .DIV(DIV), .NIBBLES(N), .CHK_SEED(5),
    .IRQ_PERIOD_STOP(PSTOP), .IRQ_PERIOD_PLAY(PPLAY), .IRQ_HOLD(HOLD)
  ) dut (
    .clk_sys(clk), .RESET(RESET), .cdd(cdd), .play_mode(play_mode),
    .stat_wr(stat_wr), .stat_idx(stat_idx), .stat_data(stat_data),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_chk_err(cmd_chk_err),
    .err_count(err_count), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // cmd_valid monitor (sampled on the inactive edge)
  always @(negedge clk) begin
    if (cmd_valid === 1'b1) begin
      vcount    <= vcount + 1;
      last_data <= cmd_data;
      last_err  <= cmd_chk_err;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_cdck(input logic v, input string tag);
    int n = 0;
    while (cdd.CDCK !== v && n < WAIT_LIM) begin
      cycles(1);
      n++;
    end
    check(tag, 64'(cdd.CDCK), 64'(v));
  endtask

  task automatic wait_nirq(input logic v, input string tag);
    int n = 0;
    while (cdd.CDD_nIRQ !== v && n < WAIT_LIM) begin
      cycles(1);
      n++;
    end
    check(tag, 64'(cdd.CDD_nIRQ), 64'(v));
  endtask

  // Host driver: ack the IRQ, read N status nibbles, send nrx command
  // nibbles. wr_nib >= 0 writes shadow idx0=9 while that nibble is on DOUT.
  task automatic do_frame(input logic [39:0] din, input int nrx, input int wr_nib,
                          output logic [39:0] dout);
    dout = '0;
    wait_nirq(1'b0, "irq_assert");
    cdd.HOCK = 1'b0;
    for (int i = 0; i < N; i++) begin
      wait_cdck(1'b0, "tx_put");
      dout[4*i +: 4] = cdd.CDD_DOUT;
      if (i == wr_nib) begin
        stat_wr = 1'b1; stat_idx = 4'd0; stat_data = 4'd9;
        cycles(1);
        stat_wr = 1'b0;
      end
      cdd.HOCK = 1'b1;
      wait_cdck(1'b1, "tx_ack");
      cdd.HOCK = 1'b0;
    end
    for (int j = 0; j < nrx; j++) begin
      wait_cdck(1'b0, "rx_req");
      cdd.CDD_DIN = din[4*j +: 4];
      cdd.HOCK = 1'b1;
      wait_cdck(1'b1, "rx_ack");
      cdd.HOCK = 1'b0;
    end
    if (nrx == N) begin
      wait_cdck(1'b0, "rx_end");
      cdd.HOCK = 1'b1;
    end
  endtask

  initial begin
    logic [39:0] dout;
    logic        cdck_low;
    int          vbefore;

    RESET = 1'b1; play_mode = 1'b0; stat_wr = 1'b0; stat_idx = '0; stat_data = '0;
    cdd.HOCK = 1'b1; cdd.CDD_DIN = '0;
    cycles(3);

    // reset values
    check("rst_cdck", 64'(cdd.CDCK), 64'd1);
    check("rst_dout", 64'(cdd.CDD_DOUT), 64'd0);
    check("rst_nirq", 64'(cdd.CDD_nIRQ), 64'd1);
    check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    check("rst_cmd_data", 64'(cmd_data), 64'd0);
    check("rst_chk_err", 64'(cmd_chk_err), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);

    // release; shadow nibble0=1, then an out-of-range write that is ignored
    RESET = 1'b0;
    stat_wr = 1'b1; stat_idx = 4'd0; stat_data = 4'd1;
    cycles(1);
    stat_idx = 4'd9; stat_data = 4'hF;
    cycles(1);
    stat_wr = 1'b0;

    // first IRQ exactly PSTOP*DIV cycles after reset release
    cycles(PSTOP*DIV - 3);
    check("pre_irq_nirq", 64'(cdd.CDD_nIRQ), 64'd1);
    check("pre_irq_cdck", 64'(cdd.CDCK), 64'd1);
    check("pre_irq_valid_count", 64'(vcount), 64'd0);
    cycles(1);
    check("first_irq_nirq", 64'(cdd.CDD_nIRQ), 64'd0);

    // full frame, good command checksum (5 + 10 = 15)
    do_frame(40'hA000000000, N, -1, dout);
    cycles(3*DIV);
    check("f1_dout", 64'(dout), 64'h9000000001);
    check("f1_valid_count", 64'(vcount), 64'd1);
    check("f1_cmd_data", 64'(last_data), 64'hA000000000);
    check("f1_chk_err", 64'(last_err), 64'd0);
    cycles(10);
    check("f1_cmd_hold", 64'(cmd_data), 64'hA000000000);

    // bad command checksum
    do_frame(40'h0000000000, N, -1, dout);
    cycles(3*DIV);
    check("f2_dout", 64'(dout), 64'h9000000001);
`ifdef CDD_LINK_CHKERR_EN
    check("f2_valid_count", 64'(vcount), 64'd2);
    check("f2_chk_err", 64'(last_err), 64'd1);
    check("f2_err_count", 64'(err_count), 64'd1);
    check("f2_cmd_data", 64'(cmd_data), 64'd0);
`else
    check("f2_valid_count", 64'(vcount), 64'd1);
    check("f2_err_count", 64'(err_count), 64'd0);
    check("f2_cmd_data", 64'(cmd_data), 64'hA000000000);
`endif
    vbefore = vcount;

    // shadow write during nibble 3 must not affect the frame in flight
    do_frame(40'hA000000000, N, 3, dout);
    cycles(3*DIV);
    check("f3_dout", 64'(dout), 64'h9000000001);
    check("f3_valid_count", 64'(vcount), 64'(vbefore + 1));

    // next frame carries the new nibble and checksum ~(5+9)=1
    do_frame(40'hA000000000, N, -1, dout);
    cycles(3*DIV);
    check("f4_dout", 64'(dout), 64'h1000000009);
    check("f4_valid_count", 64'(vcount), 64'(vbefore + 2));

    // unacknowledged IRQ: self-release after HOLD ticks, no CDCK activity
    wait_nirq(1'b0, "unack_irq");
    cdck_low = 1'b0;
    for (int c = 1; c <= 270*DIV; c++) begin
      cycles(1);
      if (cdd.CDCK !== 1'b1) cdck_low = 1'b1;
      if (c == HOLD*DIV - DIV) check("unack_hold_low", 64'(cdd.CDD_nIRQ), 64'd0);
      if (c == HOLD*DIV)       check("unack_release", 64'(cdd.CDD_nIRQ), 64'd1);
    end
    check("unack_no_cdck", 64'(cdck_low), 64'd0);

    // switch to play rate at cnt=270 (>= PPLAY-1): IRQ on the next tick
    play_mode = 1'b1;
    check("switch_pre_nirq", 64'(cdd.CDD_nIRQ), 64'd1);
    cycles(DIV);
    check("switch_irq", 64'(cdd.CDD_nIRQ), 64'd0);

    // host stalls mid-receive; next period aborts and restarts at nibble 0
    vbefore = vcount;
    do_frame(40'hA000000000, 3, -1, dout);
    check("abort_partial_dout", 64'(dout), 64'h1000000009);
    do_frame(40'hA000000000, N, -1, dout);
    cycles(3*DIV);
    check("abort_restart_dout", 64'(dout), 64'h1000000009);
    check("abort_valid_count", 64'(vcount), 64'(vbefore + 1));

    // reset in the middle of a frame
    do_frame(40'hA000000000, 2, -1, dout);
    RESET = 1'b1;
    #1;
    check("midrst_cdck", 64'(cdd.CDCK), 64'd1);
    check("midrst_nirq", 64'(cdd.CDD_nIRQ), 64'd1);
    check("midrst_dout", 64'(cdd.CDD_DOUT), 64'd0);
    check("midrst_cmd_data", 64'(cmd_data), 64'd0);
    check("midrst_state", 64'(dbg_state), 64'd0);
    cycles(2);
    RESET = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
